golden_nonce_queue: RTL and testbench

Buffers golden nonces between the hashing control unit and `serial_transmit`, so that no result is lost when a nonce is found while the UART is still sending the previous one. It is a small FIFO with a send-side handshake FSM. It sits directly downstream of the miner top's golden-ticket check and drives `serial_transmit`'s `send` and `word` inputs. It also counts nonces dropped on overflow, for the debug display.

---
 rtl/golden_nonce_queue.sv | 128 ++++++++++++
 tb/tb_golden_nonce_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_queue.sv
// Golden-nonce FIFO between the hashing control unit and serial_transmit.
// Queues found nonces, hands them out one at a time with a send/busy handshake, and counts overflow drops.
module golden_nonce_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  found,
    input  logic [31:0]           nonce_in,
    input  logic                  flush,
    input  logic                  busy,
    output logic                  send,
    output logic [31:0]           word,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic [7:0]            drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wp;
    logic [DEPTH_LOG2-1:0]   r_rp;
    logic [DEPTH_LOG2:0]     r_count;
    logic [DEPTH_LOG2:0]     w_count_nxt;
    logic                    r_full;
    logic                    r_send;
    logic [31:0]             r_word;
    logic [7:0]              r_drop;

    logic w_pop;
    logic w_push;
    logic w_drop;

    // A pop in the same cycle as a pop-freed slot lets a push into a full queue.
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !busy && !flush;
    assign w_push = found && !flush && (!r_full || w_pop);
    assign w_drop = found && !flush && r_full && !w_pop;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = S_REQ;
            S_REQ:   if (busy)  w_state_nxt = S_WAIT;
            S_WAIT:  if (!busy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= nonce_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_send  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= (w_state_nxt == S_REQ);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop)  r_rp <= r_rp + PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    // The in-flight word survives a flush; only the pop edge loads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
        end else if (w_pop) begin
            r_word <= r_mem[r_rp];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign send     = r_send;
    assign word     = r_word;
    assign count    = r_count;
    assign full     = r_full;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed bench for golden_nonce_queue with a simple serial_transmit busy model.
module tb_golden_nonce_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        found;
    logic [31:0] nonce_in;
    logic        flush;
    logic        busy;
    logic        send;
    logic [31:0] word;
    logic [3:0]  count;
    logic        full;
    logic [7:0]  drop_cnt;

    logic        force_busy = 1'b0;
    logic        model_busy = 1'b0;
    int          busy_len   = 20;
    int          n_cmp      = 0;
    int          n_fail     = 0;
    logic [31:0] sent [$];

    assign busy = force_busy | model_busy;

    golden_nonce_queue #(.DEPTH_LOG2(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .found    (found),
        .nonce_in (nonce_in),
        .flush    (flush),
        .busy     (busy),
        .send     (send),
        .word     (word),
        .count    (count),
        .full     (full),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Transmitter model: raises busy one cycle after seeing send, holds it busy_len cycles,
    // and records every word presented on a rising send.
    int   m_cnt  = 0;
    logic m_pend = 1'b0;
    logic m_prev = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_cnt  = 0;
            m_pend = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end else if (m_pend) begin
            m_cnt  = busy_len;
            m_pend = 1'b0;
        end else if (send) begin
            m_pend = 1'b1;
        end
        model_busy = (m_cnt > 0);
        if (send && !m_prev) sent.push_back(word);
        m_prev = send;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sent(input int n, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (sent.size() >= n) break;
            tick();
        end
    endtask

    task automatic push(input logic [31:0] v);
        found    = 1'b1;
        nonce_in = v;
        tick();
    endtask

    initial begin
        reset_n  = 1'b1;
        found    = 1'b0;
        nonce_in = '0;
        flush    = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_send", 32'(send), 0);
        check("rst_word", word, 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Single nonce with a 20-cycle busy transmitter
        busy_len = 20;
        push(32'h1D6C_0A3F);
        found = 1'b0;
        check("t1_count_t", 32'(count), 1);
        check("t1_send_t", 32'(send), 0);
        tick();
        check("t1_send_t1", 32'(send), 1);
        check("t1_word_t1", word, 32'h1D6C_0A3F);
        check("t1_count_t1", 32'(count), 0);
        tick();
        check("t1_send_t2", 32'(send), 1);
        tick();
        check("t1_send_drop", 32'(send), 0);
        check("t1_word_hold", word, 32'h1D6C_0A3F);
        repeat (40) tick();
        check("t1_count_end", 32'(count), 0);
        check("t1_nsent", sent.size(), 1);
        check("t1_sent0", sent[0], 32'h1D6C_0A3F);

        // Ordering with busy held high while pushing
        sent.delete();
        busy_len   = 3;
        force_busy = 1'b1;
        push(32'h11);
        push(32'h22);
        push(32'h33);
        found = 1'b0;
        check("t2_count3", 32'(count), 3);
        force_busy = 1'b0;
        wait_sent(3, 100);
        repeat (20) tick();
        check("t2_nsent", sent.size(), 3);
        check("t2_sent0", sent[0], 32'h11);
        check("t2_sent1", sent[1], 32'h22);
        check("t2_sent2", sent[2], 32'h33);
        check("t2_count_end", 32'(count), 0);

        // Overflow: ten pushes into an eight-entry queue
        sent.delete();
        busy_len   = 2;
        force_busy = 1'b1;
        for (int i = 0; i < 10; i++) push(32'(i));
        found = 1'b0;
        check("t3_full", 32'(full), 1);
        check("t3_count", 32'(count), 8);
        check("t3_drop", 32'(drop_cnt), 2);
        force_busy = 1'b0;
        wait_sent(8, 300);
        repeat (20) tick();
        check("t3_nsent", sent.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("t3_sent%0d", i), sent[i], 32'(i));
        check("t3_full_end", 32'(full), 0);

        // Full queue with a push coinciding with a pop
        sent.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(32'h40 + 32'(i));
        check("t4_count_full", 32'(count), 8);
        check("t4_full", 32'(full), 1);
        force_busy = 1'b0;
        nonce_in   = 32'hAA;
        tick();
        found = 1'b0;
        check("t4_count_pp", 32'(count), 8);
        check("t4_drop_pp", 32'(drop_cnt), 2);
        check("t4_send_pp", 32'(send), 1);
        check("t4_word_pp", word, 32'h40);
        wait_sent(9, 300);
        repeat (20) tick();
        check("t4_nsent", sent.size(), 9);
        check("t4_first", sent[0], 32'h40);
        check("t4_last", sent[8], 32'hAA);
        check("t4_drop_end", 32'(drop_cnt), 2);

        // Flush during WAIT together with a found
        sent.delete();
        busy_len   = 5;
        force_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'h50 + 32'(i));
        found = 1'b0;
        check("t5_count4", 32'(count), 4);
        force_busy = 1'b0;
        tick();
        check("t5_send", 32'(send), 1);
        check("t5_word", word, 32'h51);
        check("t5_count3", 32'(count), 3);
        tick();
        tick();
        check("t5_wait_send", 32'(send), 0);
        flush    = 1'b1;
        found    = 1'b1;
        nonce_in = 32'hBB;
        tick();
        flush = 1'b0;
        found = 1'b0;
        check("t5_count_flush", 32'(count), 0);
        check("t5_full_flush", 32'(full), 0);
        check("t5_drop_flush", 32'(drop_cnt), 2);
        check("t5_word_flush", word, 32'h51);
        repeat (30) tick();
        check("t5_nsent", sent.size(), 1);
        check("t5_sent0", sent[0], 32'h51);
        check("t5_count_end", 32'(count), 0);

        // Asynchronous reset while in REQ
        sent.delete();
        busy_len = 3;
        push(32'h66);
        found = 1'b0;
        tick();
        check("t6_send_req", 32'(send), 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_send", 32'(send), 0);
        check("t6_word", word, 0);
        check("t6_count", 32'(count), 0);
        check("t6_drop", 32'(drop_cnt), 0);
        check("t6_full", 32'(full), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_send_after", 32'(send), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
